wb_cmd_master: RTL and testbench

Single-outstanding Wishbone pipelined initiator. Accepts one read or write command on a valid/ready port, runs one Wishbone cycle on the system bus, and returns read data and error status on a valid/ready response port. Sits between simple command sources (debug bridge, boot loader, test sequencer) and the shared Wishbone crossbar that serves peripherals such as the GPIO block.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_if.sv | 23 ++
 rtl/wb_master_timer.sv | 29 ++
 rtl/wb_cmd_master.sv | 134 +++++++++++++
 tb/tb_wb_cmd_master.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the single-outstanding Wishbone command master.
package wb_master_pkg;

   localparam int TIMEOUT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RSP
   } state_t;

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
      logic        timeout;
   } rsp_t;

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle (32-bit data, byte-lane selects).
interface wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        stall;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, sel, dat_m,
      input  dat_s, stall, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_m,
      output dat_s, stall, ack, err
   );
endinterface

// File: rtl/wb_master_timer.sv
// Abort timer for the command master: cleared when the strobe is accepted,
// counts while waiting for ack/err, flags expiry when the count hits limit.
import wb_master_pkg::*;

module wb_master_timer (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 en,
   input  logic [TIMEOUT_W-1:0] limit,
   output logic                 expire
);

   logic [TIMEOUT_W-1:0] cnt;

   // Wait-cycle counter: restart on strobe acceptance, advance while waiting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = en && (cnt == limit);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus
// cycle out, one response back. Optional abort timer is enabled by defining
// WB_MASTER_TIMEOUT_EN; without it the master waits for ack/err forever.
import wb_master_pkg::*;

module wb_cmd_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_timeout,
   wb_if.master        wb
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t      state;
   state_t      next;
   rsp_t        rsp_q;
   rsp_t        rsp_next;
   logic        cyc_q;
   logic        stb_q;
   logic        we_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        accept;
   logic        term;
   logic        tmo;

   // The strobe is taken by the slave in any REQ cycle without stall.
   assign accept = (state == REQ) && !wb.stall;
   // A bus cycle terminates on ack/err once the strobe has been taken.
   assign term   = (accept || (state == WAIT)) && (wb.ack || wb.err);

`ifdef WB_MASTER_TIMEOUT_EN
   wb_master_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .en     (state == WAIT),
      .limit  (TIMEOUT_W'(TIMEOUT_CYCLES - 1)),
      .expire (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // Next-state decode and response capture; ack/err beat a same-cycle timeout.
   always_comb begin
      next     = state;
      rsp_next = rsp_q;
      case (state)
         IDLE: if (cmd_valid) next = REQ;
         REQ:  if (!wb.stall) next = (wb.ack || wb.err) ? RSP : WAIT;
         WAIT: if (wb.ack || wb.err || tmo) next = RSP;
         RSP:  if (rsp_ready) next = IDLE;
         default: next = IDLE;
      endcase
      if (term) begin
         rsp_next.err     = wb.err;
         rsp_next.timeout = 1'b0;
         rsp_next.dat     = (wb.err || we_q) ? 32'h0 : wb.dat_s;
      end else if ((state == WAIT) && tmo) begin
         rsp_next.err     = 1'b1;
         rsp_next.timeout = 1'b1;
         rsp_next.dat     = 32'h0;
      end
   end

   // Registered bus/response handshake outputs, decoded from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
      end else begin
         cyc_q     <= (next == REQ) || (next == WAIT);
         stb_q     <= (next == REQ);
         rsp_valid <= (next == RSP);
         rsp_q     <= rsp_next;
      end
   end

   // Command fields latched on acceptance and held for the whole bus cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q  <= 1'b0;
         adr_q <= 32'h0;
         dat_q <= 32'h0;
         sel_q <= 4'h0;
      end else if ((state == IDLE) && cmd_valid) begin
         we_q  <= cmd_we;
         adr_q <= cmd_adr;
         dat_q <= cmd_dat;
         sel_q <= cmd_sel;
      end
   end

   assign cmd_ready   = rst_n && (state == IDLE);
   assign rsp_dat     = rsp_q.dat;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

   assign wb.cyc   = cyc_q;
   assign wb.stb   = stb_q;
   assign wb.we    = we_q;
   assign wb.adr   = adr_q;
   assign wb.sel   = sel_q;
   assign wb.dat_m = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: the slave side is driven by hand, cycle
// by cycle, and every expected value is written out in the sequence below.
module tb_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = 32'h0;
   logic [31:0] cmd_dat = 32'h0;
   logic [3:0]  cmd_sel = 4'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_timeout;

   int tests = 0;
   int fails = 0;

   wb_if bus ();

   wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_adr     (cmd_adr),
      .cmd_dat     (cmd_dat),
      .cmd_sel     (cmd_sel),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_dat     (rsp_dat),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .wb          (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.ack   = 1'b0;
      bus.err   = 1'b0;
      bus.dat_s = 32'h0;

      // ---------------- reset state
      step();
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_cyc", 32'(bus.cyc), 0);
      chk("rst_stb", 32'(bus.stb), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_dat", rsp_dat, 0);
      chk("rst_adr", bus.adr, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

      // ---------------- write 0xFF to 0x8, slave acks one cycle after stb
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h8; cmd_dat = 32'hFF; cmd_sel = 4'hF;
      step();                                   // cycle 1
      cmd_valid = 1'b0;
      chk("wr_c1_cyc", 32'(bus.cyc), 1);
      chk("wr_c1_stb", 32'(bus.stb), 1);
      chk("wr_c1_we", 32'(bus.we), 1);
      chk("wr_c1_sel", 32'(bus.sel), 32'hF);
      chk("wr_c1_adr", bus.adr, 32'h8);
      chk("wr_c1_dat", bus.dat_m, 32'hFF);
      chk("wr_c1_cmd_ready", 32'(cmd_ready), 0);
      step();                                   // cycle 2
      bus.ack = 1'b1;
      chk("wr_c2_cyc", 32'(bus.cyc), 1);
      chk("wr_c2_stb", 32'(bus.stb), 0);
      chk("wr_c2_rsp_valid", 32'(rsp_valid), 0);
      step();                                   // cycle 3
      bus.ack = 1'b0;
      chk("wr_c3_rsp_valid", 32'(rsp_valid), 1);
      chk("wr_c3_rsp_err", 32'(rsp_err), 0);
      chk("wr_c3_rsp_dat", rsp_dat, 0);
      chk("wr_c3_rsp_timeout", 32'(rsp_timeout), 0);
      chk("wr_c3_cyc", 32'(bus.cyc), 0);
      rsp_ready = 1'b1;
      step();                                   // cycle 4
      rsp_ready = 1'b0;
      chk("wr_c4_rsp_valid", 32'(rsp_valid), 0);
      chk("wr_c4_cmd_ready", 32'(cmd_ready), 1);

      // ---------------- read 0x10, stall for 3 cycles, data 0xDEADBEEF
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_dat = 32'h0; cmd_sel = 4'hF;
      step();
      cmd_valid = 1'b0;
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rd_stall_stb", 32'(bus.stb), 1);
         chk("rd_stall_adr", bus.adr, 32'h10);
         step();
      end
      bus.stall = 1'b0;
      chk("rd_stb_4th", 32'(bus.stb), 1);
      chk("rd_adr_4th", bus.adr, 32'h10);
      chk("rd_we", 32'(bus.we), 0);
      step();
      chk("rd_wait_stb", 32'(bus.stb), 0);
      chk("rd_wait_cyc", 32'(bus.cyc), 1);
      bus.ack = 1'b1; bus.dat_s = 32'hDEADBEEF;
      step();
      bus.ack = 1'b0; bus.dat_s = 32'h0;
      chk("rd_rsp_valid", 32'(rsp_valid), 1);
      chk("rd_rsp_dat", rsp_dat, 32'hDEADBEEF);
      chk("rd_rsp_err", 32'(rsp_err), 0);

      // ---------------- response back-pressure; stray ack/err in RSP ignored
      for (int i = 0; i < 5; i++) begin
         bus.ack = (i == 1); bus.err = (i == 2); bus.dat_s = 32'h1234;
         chk("hold_rsp_valid", 32'(rsp_valid), 1);
         chk("hold_rsp_dat", rsp_dat, 32'hDEADBEEF);
         chk("hold_rsp_err", 32'(rsp_err), 0);
         chk("hold_cmd_ready", 32'(cmd_ready), 0);
         chk("hold_cyc", 32'(bus.cyc), 0);
         step();
      end
      bus.ack = 1'b0; bus.err = 1'b0; bus.dat_s = 32'h0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hold_release_valid", 32'(rsp_valid), 0);
      chk("hold_release_ready", 32'(cmd_ready), 1);

      // ---------------- read with err+ack together, combinational with stb
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h20; cmd_sel = 4'h3;
      step();
      cmd_valid = 1'b0;
      chk("err_stb", 32'(bus.stb), 1);
      chk("err_sel", 32'(bus.sel), 32'h3);
      bus.ack = 1'b1; bus.err = 1'b1; bus.dat_s = 32'h55;
      step();
      bus.ack = 1'b0; bus.err = 1'b0; bus.dat_s = 32'h0;
      chk("err_rsp_valid", 32'(rsp_valid), 1);
      chk("err_rsp_err", 32'(rsp_err), 1);
      chk("err_rsp_dat", rsp_dat, 0);
      chk("err_rsp_timeout", 32'(rsp_timeout), 0);
      chk("err_cyc", 32'(bus.cyc), 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("err_next_ready", 32'(cmd_ready), 1);

      // ---------------- next command accepted, then reset while in WAIT
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h30; cmd_dat = 32'hA5A5; cmd_sel = 4'hC;
      step();
      cmd_valid = 1'b0;
      chk("nxt_stb", 32'(bus.stb), 1);
      chk("nxt_adr", bus.adr, 32'h30);
      step();
      chk("nxt_wait_cyc", 32'(bus.cyc), 1);
      chk("nxt_wait_stb", 32'(bus.stb), 0);
      rst_n = 1'b0;
      step();
      chk("wrst_cyc", 32'(bus.cyc), 0);
      chk("wrst_stb", 32'(bus.stb), 0);
      chk("wrst_rsp_valid", 32'(rsp_valid), 0);
      chk("wrst_adr", bus.adr, 0);
      chk("wrst_cmd_ready", 32'(cmd_ready), 0);
      rst_n = 1'b1;
      bus.ack = 1'b1;
      #1;
      chk("wrst_idle_ready", 32'(cmd_ready), 1);
      step();
      bus.ack = 1'b0;
      chk("late_ack_rsp_valid", 32'(rsp_valid), 0);
      chk("late_ack_cyc", 32'(bus.cyc), 0);
      chk("late_ack_ready", 32'(cmd_ready), 1);

`ifdef WB_MASTER_TIMEOUT_EN
      // ---------------- timeout: slave never answers, TIMEOUT_CYCLES=8
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_sel = 4'hF;
      step();
      cmd_valid = 1'b0;
      chk("tmo_stb", 32'(bus.stb), 1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("tmo_wait_cyc", 32'(bus.cyc), 1);
         chk("tmo_wait_valid", 32'(rsp_valid), 0);
      end
      step();
      chk("tmo_cyc_drop", 32'(bus.cyc), 0);
      chk("tmo_rsp_valid", 32'(rsp_valid), 1);
      chk("tmo_rsp_err", 32'(rsp_err), 1);
      chk("tmo_rsp_timeout", 32'(rsp_timeout), 1);
      chk("tmo_rsp_dat", rsp_dat, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("tmo_ready", 32'(cmd_ready), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
